// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational fp adder among requesters,
// with burst lock and a single registered response slot.
module fp_add_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int LOCK_MAX = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_lock,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [7:0]           rsp_status,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  input  logic [31:0]          add_z,
  input  logic [7:0]           add_status
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  localparam logic [0:0] UNLOCKED = 1'b0;
  localparam logic [0:0] LOCKED   = 1'b1;

  logic [0:0]    lock_state;
  logic [IW-1:0] lock_own;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] next_cnt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_next;
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic          slot_free;
  logic          lock_hit;
  int            j;

  assign slot_free = ~|rsp_valid | |(rsp_valid & rsp_ready);
  assign lock_hit  = (lock_state == LOCKED) && req_valid[lock_own];

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    if (reset_n && slot_free) begin
      if (lock_hit) begin
        gnt_any = 1'b1;
        gnt_idx = lock_own;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          j = (int'(rr_ptr) + k) % NUM_REQ;
          if (!gnt_any && req_valid[IW'(j)]) begin
            gnt_any = 1'b1;
            gnt_idx = IW'(j);
          end
        end
      end
    end
  end

  assign req_ready = NUM_REQ'(gnt_any) << gnt_idx;
  assign rr_next   = IW'((int'(gnt_idx) + 1) % NUM_REQ);

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && gnt_idx == IW'(i)) begin
        add_a = req_a[32*i +: 32];
        add_b = req_b[32*i +: 32];
      end
    end
  end

  // A continuing burst counts up; any new owner restarts the count at 1.
  assign next_cnt = (lock_state == LOCKED && gnt_idx == lock_own)
                  ? lock_cnt + CW'(1) : CW'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_status <= '0;
      rr_ptr     <= '0;
      lock_state <= UNLOCKED;
      lock_own   <= '0;
      lock_cnt   <= '0;
    end else begin
      if (gnt_any) begin
        rsp_valid  <= req_ready;
        rsp_data   <= add_z;
        rsp_status <= add_status;
        rr_ptr     <= rr_next;
      end else if (slot_free) begin
        rsp_valid <= '0;
      end

      if (gnt_any) begin
        if (req_lock[gnt_idx] && next_cnt < CW'(LOCK_MAX)) begin
          lock_state <= LOCKED;
          lock_own   <= gnt_idx;
          lock_cnt   <= next_cnt;
        end else begin
          lock_state <= UNLOCKED;
          lock_cnt   <= '0;
        end
      end else if (slot_free && lock_state == LOCKED
                   && !req_valid[lock_own]) begin
        lock_state <= UNLOCKED;
        lock_cnt   <= '0;
      end
    end
  end

endmodule
